mult_seq_param: RTL and testbench
=================================

# mult_seq_param

Parametrised sequential shift-add multiplier. It is the successor to the fixed 4x4 control-unit/datapath multiplier: operand width is generic, signed or unsigned operation is chosen per transaction, and a start/busy/done handshake replaces free-running control. It sits behind the top-level pin wrapper, which maps the operands from the dedicated inputs and the product to the dedicated outputs.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2..16. The product is 2*WIDTH bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply. Sampled only in IDLE.
- signed_mode  in  1  selects the operand format, captured with start.
  - 1 = two's complement.
  - 0 = unsigned.
- a  in  WIDTH  multiplicand, captured with start.
- b  in  WIDTH  multiplier, captured with start.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse when product is updated.
- product  out  2*WIDTH  last completed result. Held until the next done.

## Operation
- State machine: IDLE -> RUN -> SIGN -> IDLE.
- **IDLE** (busy=0):
  - On start=1, capture signed_mode.
  - mcand := |a| and mplier := |b| (WIDTH bits each). The magnitudes are the raw values when unsigned.
  - neg := signed_mode & (a[MSB] ^ b[MSB]).
  - acc := 0 (WIDTH+1 bits); count := 0. Go to RUN.
- **RUN** (busy=1), one iteration per cycle:
  - sum := acc + (mplier[0] ? mcand : 0), computed WIDTH+1 bits wide with no overflow.
  - {acc, mplier} := {sum, mplier} >> 1 (logical).
  - count := count + 1. After the WIDTH-th iteration, go to SIGN.
- **SIGN** (busy=1):
  - raw := {acc[WIDTH-1:0], mplier}.
  - product := neg ? (~raw + 1) : raw, truncated to 2*WIDTH bits.
  - done := 1 for this edge only. Go to IDLE.
- Magnitude of the most negative operand: -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. No special case is needed.
- Every signed and unsigned result fits in 2*WIDTH bits. There is no overflow flag.
- start while busy=1 is ignored. Operand changes during RUN/SIGN have no effect.
- The count register is clog2(WIDTH+1) bits.

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE. All internal registers are 0.
- Let E0 be the edge that samples start in IDLE.
  - busy rises after E0.
  - Edges E1..E(WIDTH) perform the iterations.
  - At edge E(WIDTH+1), product is loaded, done=1, and busy=0.
- Latency: done and the new product are visible WIDTH+1 cycles after the start-sampling edge. Transaction period is WIDTH+2 cycles.
- The done cycle is an IDLE cycle, so start=1 during it is accepted.
  - With start held high, back-to-back transactions run every WIDTH+2 cycles.
- done is never high for two consecutive cycles.
- product changes only on the done edge or at reset.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously) and the state returns to IDLE. The partial result is discarded and no done is produced. After rst_n rises, the first clock edge can accept start.
- busy and done are registered outputs with no combinational path from the inputs.

## Test plan
- WIDTH=4, unsigned: a=15, b=15, one-cycle start.
  - Required: busy high for exactly 5 cycles.
  - Required: done pulses 5 cycles after the start edge with product=225 (0xE1), and product is held afterwards.
- WIDTH=4, signed:
  - a=-8, b=-8 -> product=64.
  - a=-8, b=7 -> product=-56 (0xC8).
  - a=3, b=-1 -> product=-3 (0xFD).
  - a=0, b=-5 -> product=0.
- WIDTH=4, start and operand changes while busy:
  - Start a=2, b=3; toggle start and change a/b during RUN.
  - Required: exactly one done, with product=6.
- WIDTH=4, start held high for 3 transactions with a=5, b=6, unsigned.
  - Required: done pulses spaced 6 cycles apart, each with product=30. busy is low only during the done cycles.
- Reset mid-run: WIDTH=4, a=9, b=9; deassert rst_n on the third RUN cycle.
  - Required: busy/done/product go to 0 immediately with no done.
  - Required: a new a=9, b=9 run afterwards gives 81.
- WIDTH=8, random: 1000 random signed and unsigned vectors checked against a reference model.
  - Required: all products match.
  - Required: done latency is always 9 cycles.

Source files
------------

// File: rtl/mult_seq_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mult_seq_param_if                                      |
// | Description : Handshake/operand bundle for the sequential multiplier.|
// |               The master side requests a product, the slave side     |
// |               computes it.                                           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface mult_seq_param_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/mult_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mult_seq_param                                         |
// | Description : Parametrised shift-add multiplier with start/busy/done |
// |               handshake. Signed operands are multiplied as           |
// |               magnitudes and the sign is applied in a final cycle.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mult_seq_param #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_seq_param_if.slave   bus
);

  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [WIDTH-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [WIDTH:0]       acc_q,     acc_d;
  logic                 neg_q,     neg_d;
  logic [CW-1:0]        count_q,   count_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   raw;

  // Next-state and datapath: capture magnitudes, iterate shift-add, apply sign
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    // acc never exceeds WIDTH bits after a shift, so WIDTH+1 bits cannot overflow
    sum = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    raw = {acc_q[WIDTH-1:0], mplier_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
          mcand_d  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          mplier_d = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = {1'b0, sum[WIDTH:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        product_d = neg_q ? (~raw + (2*WIDTH)'(1)) : raw;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous clear of all state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mult_seq_param                                      |
// | Description : Self-checking bench for mult_seq_param at WIDTH=4 and  |
// |               WIDTH=8 against an arithmetic reference model.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mult_seq_param;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mult_seq_param_if #(.WIDTH(4)) bus4 ();
  mult_seq_param_if #(.WIDTH(8)) bus8 ();

  mult_seq_param #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mult_seq_param #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers, multiply, keep 2*w bits
  function automatic longint ref_mul(int w, bit sm, longint a, longint b);
    longint sa, sb, p;
    sa = a;
    sb = b;
    if (sm && a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
    if (sm && b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
    p = sa * sb;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // One WIDTH=4 transaction; called at posedge+1, returns at posedge+1 of done
  task automatic run4(input bit sm, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] prod, output int lat, output int busy_n);
    bus4.start       = 1'b1;
    bus4.signed_mode = sm;
    bus4.a           = a;
    bus4.b           = b;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    busy_n = bus4.busy ? 1 : 0;
    lat    = -1;
    prod   = 'x;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus4.done) begin
        lat  = k;
        prod = bus4.product;
      end else if (bus4.busy) begin
        busy_n++;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus4.busy !== 1'b0) $display("FAIL reset_busy4: got %b expected 0", bus4.busy); else n_pass++;
    n_checks++; if (bus4.done !== 1'b0) $display("FAIL reset_done4: got %b expected 0", bus4.done); else n_pass++;
    n_checks++; if (bus4.product !== 8'h00) $display("FAIL reset_product4: got %h expected 00", bus4.product); else n_pass++;
    n_checks++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy8: got %b expected 0", bus8.busy); else n_pass++;
    n_checks++; if (bus8.product !== 16'h0000) $display("FAIL reset_product8: got %h expected 0000", bus8.product); else n_pass++;
  endtask

  task automatic test_unsigned_basic();
    logic [7:0] prod;
    int lat, busy_n;
    run4(1'b0, 4'd15, 4'd15, prod, lat, busy_n);
    n_checks++; if (prod !== 8'hE1) $display("FAIL u15x15_product: got %h expected e1", prod); else n_pass++;
    n_checks++; if (lat !== 5) $display("FAIL u15x15_latency: got %0d expected 5", lat); else n_pass++;
    n_checks++; if (busy_n !== 5) $display("FAIL u15x15_busy_cycles: got %0d expected 5", busy_n); else n_pass++;
    n_checks++; if (bus4.busy !== 1'b0) $display("FAIL u15x15_busy_at_done: got %b expected 0", bus4.busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus4.done !== 1'b0) $display("FAIL u15x15_done_single: got %b expected 0", bus4.done); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus4.product !== 8'hE1) $display("FAIL u15x15_hold: got %h expected e1", bus4.product); else n_pass++;
  endtask

  task automatic test_signed();
    logic [3:0] va [4] = '{4'h8, 4'h8, 4'h3, 4'h0};
    logic [3:0] vb [4] = '{4'h8, 4'h7, 4'hF, 4'hB};
    logic [7:0] ve [4] = '{8'h40, 8'hC8, 8'hFD, 8'h00};
    logic [7:0] prod;
    int lat, busy_n;
    for (int i = 0; i < 4; i++) begin
      run4(1'b1, va[i], vb[i], prod, lat, busy_n);
      n_checks++;
      if (prod !== ve[i]) $display("FAIL signed_%0d: a=%h b=%h got %h expected %h", i, va[i], vb[i], prod, ve[i]);
      else n_pass++;
      n_checks++;
      if (lat !== 5) $display("FAIL signed_lat_%0d: got %0d expected 5", i, lat); else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int n_done;
    logic [7:0] prod;
    n_done = 0;
    prod   = 'x;
    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.a = 4'd2; bus4.b = 4'd3;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      // Only disturb inputs sampled while the DUT is still in RUN/SIGN
      if (k <= 5) begin
        bus4.start       = ~bus4.start;
        bus4.a           = 4'($urandom);
        bus4.b           = 4'($urandom);
        bus4.signed_mode = 1'($urandom);
      end else begin
        bus4.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus4.done) begin
        n_done++;
        prod = bus4.product;
      end
    end
    n_checks++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d expected 1", n_done); else n_pass++;
    n_checks++; if (prod !== 8'd6) $display("FAIL ignore_product: got %0d expected 6", prod); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t_done [$];
    int viol;
    viol = 0;
    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.a = 4'd5; bus4.b = 4'd6;
    @(posedge clk); #1;
    for (int t = 1; t <= 30 && t_done.size() < 3; t++) begin
      @(posedge clk); #1;
      if (bus4.busy === bus4.done) viol++;
      if (bus4.done) begin
        t_done.push_back(t);
        n_checks++;
        if (bus4.product !== 8'd30) $display("FAIL b2b_product: got %0d expected 30", bus4.product); else n_pass++;
        if (t_done.size() == 3) bus4.start = 1'b0;
      end
    end
    bus4.start = 1'b0;
    n_checks++; if (t_done.size() !== 3) $display("FAIL b2b_count: got %0d expected 3", t_done.size()); else n_pass++;
    if (t_done.size() == 3) begin
      n_checks++; if (t_done[0] !== 5) $display("FAIL b2b_first: got %0d expected 5", t_done[0]); else n_pass++;
      n_checks++; if (t_done[1] - t_done[0] !== 6) $display("FAIL b2b_gap1: got %0d expected 6", t_done[1] - t_done[0]); else n_pass++;
      n_checks++; if (t_done[2] - t_done[1] !== 6) $display("FAIL b2b_gap2: got %0d expected 6", t_done[2] - t_done[1]); else n_pass++;
    end
    n_checks++; if (viol !== 0) $display("FAIL b2b_busy_vs_done: got %0d violations expected 0", viol); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midrun();
    int n_done;
    logic [7:0] prod;
    int lat, busy_n;
    n_done = 0;
    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.a = 4'd9; bus4.b = 4'd9;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus4.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus4.busy); else n_pass++;
    n_checks++; if (bus4.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus4.done); else n_pass++;
    n_checks++; if (bus4.product !== 8'h00) $display("FAIL midrst_product: got %h expected 00", bus4.product); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus4.done) n_done++;
    end
    n_checks++; if (n_done !== 0) $display("FAIL midrst_spurious_done: got %0d expected 0", n_done); else n_pass++;
    run4(1'b0, 4'd9, 4'd9, prod, lat, busy_n);
    n_checks++; if (prod !== 8'd81) $display("FAIL midrst_rerun: got %0d expected 81", prod); else n_pass++;
  endtask

  task automatic test_random8();
    logic [7:0]  ca [4] = '{8'h80, 8'hFF, 8'h80, 8'hFF};
    logic [7:0]  cb [4] = '{8'h80, 8'hFF, 8'h7F, 8'h01};
    bit          cs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  a, b;
    bit          sm;
    logic [63:0] got, exp;
    int          lat;
    for (int i = 0; i < 1000; i++) begin
      if (i < 4) begin
        a = ca[i]; b = cb[i]; sm = cs[i];
      end else begin
        a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom_range(0, 1));
      end
      exp = 64'(ref_mul(8, sm, longint'(a), longint'(b)));
      bus8.start = 1'b1; bus8.signed_mode = sm; bus8.a = a; bus8.b = b;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      lat = -1;
      got = 'x;
      for (int k = 1; k <= 30 && lat < 0; k++) begin
        @(posedge clk); #1;
        if (bus8.done) begin
          lat = k;
          got = 64'(bus8.product);
        end
      end
      n_checks++;
      if (got !== exp) $display("FAIL rand8_product: sm=%0d a=%h b=%h got %h expected %h", sm, a, b, got, exp);
      else n_pass++;
      n_checks++;
      if (lat !== 9) $display("FAIL rand8_latency: got %0d expected 9", lat); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_unsigned_basic();
    test_signed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midrun();
    test_random8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
